// File: rtl/bin_mul_pkg.sv
// Shared widths and the result payload for the multiplier issue/collect stage.
package bin_mul_pkg;

    localparam int unsigned WIDTH      = 13;
    localparam int unsigned LATENCY    = 14;
    localparam int unsigned PROD_W     = 2 * WIDTH;
    localparam int unsigned TAG_W      = 4;
    localparam int unsigned FIFO_DEPTH = 32;

    localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned INFL_W   = $clog2(LATENCY + 2);
    localparam int unsigned CREDIT_W = CNT_W + 1;

    typedef struct packed {
        logic [PROD_W-1:0] product;
        logic [TAG_W-1:0]  tag;
    } res_t;

    localparam int unsigned RES_W = $bits(res_t);

endpackage

// File: rtl/bin_mul_res_fifo.sv
// Synchronous result FIFO with a registered head entry, valid flag and occupancy count.
module bin_mul_res_fifo #(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned DATA_W = 30
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [DATA_W-1:0]      push_data,
    input  logic                   pop,
    output logic [DATA_W-1:0]      head,
    output logic                   valid,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     rd_ptr_nxt;
    logic [CW-1:0]     count_nxt;
    logic              do_pop;

    always_comb begin
        do_pop     = pop && valid;
        rd_ptr_nxt = do_pop ? rd_ptr + AW'(1) : rd_ptr;
        count_nxt  = count;
        if (push && !do_pop) begin
            count_nxt = count + CW'(1);
        end else if (!push && do_pop) begin
            count_nxt = count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Head is preloaded from the next read slot, bypassing a write that lands there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= 1'b0;
            head   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
            valid  <= (count_nxt != '0);
            if (count_nxt != '0) begin
                head <= (push && (wr_ptr == rd_ptr_nxt)) ? push_data : mem[rd_ptr_nxt];
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && (count == CW'(DEPTH))));

endmodule

// File: rtl/bin_mul_stream_ctrl.sv
// Issue/collect stage around a fixed-latency multiplier; credit-based issue keeps
// the result FIFO from overflowing while the multiplier runs freely.
module bin_mul_stream_ctrl
    import bin_mul_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [WIDTH-1:0]  in_b,
    input  logic [TAG_W-1:0]  in_tag,
    output logic [WIDTH-1:0]  mul_a,
    output logic [WIDTH-1:0]  mul_b,
    output logic              mul_en,
    input  logic [PROD_W-1:0] mul_p,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] out_p,
    output logic [TAG_W-1:0]  out_tag
);
    logic                accept;
    logic                push;
    logic                pop;
    logic [LATENCY:0]    pipe_v;
    logic [TAG_W-1:0]    pipe_tag [LATENCY+1];
    logic [INFL_W-1:0]   inflight;
    logic [INFL_W-1:0]   inflight_nxt;
    logic [CNT_W-1:0]    fifo_count;
    logic [CNT_W-1:0]    fifo_count_nxt;
    logic [CREDIT_W-1:0] used_nxt;
    res_t                push_res;
    res_t                head_res;

    assign accept   = in_valid && in_ready;
    assign push     = pipe_v[LATENCY];
    assign pop      = out_valid && out_ready;
    assign push_res = '{product: mul_p, tag: pipe_tag[LATENCY]};
    assign out_p    = head_res.product;
    assign out_tag  = head_res.tag;

    // Credits in use after this edge: operations still in the multiplier plus stored results.
    always_comb begin
        inflight_nxt = inflight;
        if (accept && !push) begin
            inflight_nxt = inflight + INFL_W'(1);
        end else if (!accept && push) begin
            inflight_nxt = inflight - INFL_W'(1);
        end
        fifo_count_nxt = fifo_count;
        if (push && !pop) begin
            fifo_count_nxt = fifo_count + CNT_W'(1);
        end else if (!push && pop) begin
            fifo_count_nxt = fifo_count - CNT_W'(1);
        end
        used_nxt = CREDIT_W'(inflight_nxt) + CREDIT_W'(fifo_count_nxt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a    <= '0;
            mul_b    <= '0;
            mul_en   <= 1'b0;
            in_ready <= 1'b0;
            inflight <= '0;
            pipe_v   <= '0;
            for (int unsigned i = 0; i <= LATENCY; i++) begin
                pipe_tag[i] <= '0;
            end
        end else begin
            mul_en   <= 1'b1;
            in_ready <= (used_nxt < CREDIT_W'(FIFO_DEPTH));
            inflight <= inflight_nxt;
            pipe_v   <= {pipe_v[LATENCY-1:0], accept};
            if (accept) begin
                mul_a       <= in_a;
                mul_b       <= in_b;
                pipe_tag[0] <= in_tag;
            end
            for (int unsigned i = 1; i <= LATENCY; i++) begin
                pipe_tag[i] <= pipe_tag[i-1];
            end
        end
    end

    bin_mul_res_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (RES_W)
    ) u_res_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_res),
        .pop       (pop),
        .head      (head_res),
        .valid     (out_valid),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_bin_mul_stream_ctrl.sv
// Bench for bin_mul_stream_ctrl with a behavioural 14-cycle multiplier and a queue scoreboard.
module tb_bin_mul_stream_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [12:0] in_a = '0;
    logic [12:0] in_b = '0;
    logic [3:0]  in_tag = '0;
    logic [12:0] mul_a;
    logic [12:0] mul_b;
    logic        mul_en;
    logic [25:0] mul_p;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [25:0] out_p;
    logic [3:0]  out_tag;

    always #5 clk = ~clk;

    bin_mul_stream_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_en    (mul_en),
        .mul_p     (mul_p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .out_tag   (out_tag)
    );

    // Fixed-latency multiplier: product of the presented operands appears 14 edges later.
    logic [25:0] mpipe [14];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 14; i++) mpipe[i] <= '0;
        end else if (mul_en) begin
            mpipe[0] <= 26'(mul_a) * 26'(mul_b);
            for (int i = 1; i < 14; i++) mpipe[i] <= mpipe[i-1];
        end
    end
    assign mul_p = mpipe[13];

    typedef struct {
        longint unsigned p;
        longint unsigned tag;
        longint unsigned rdy;
    } exp_t;

    exp_t            sb[$];
    int              n_tests = 0;
    int              n_fail  = 0;
    longint unsigned cyc     = 0;
    bit              started = 1'b0;
    int              n_acc   = 0;
    int              n_pops  = 0;

    task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: drive at the falling edge, check against the model, then advance.
    task automatic cycle(input logic v, input logic [12:0] a, input logic [12:0] b,
                         input logic [3:0] t, input logic r);
        bit exp_ov;
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_tag    = t;
        out_ready = r;
        exp_ov = (sb.size() > 0) && (sb[0].rdy <= cyc);
        check("in_ready", 64'(in_ready), 64'(started && (sb.size() < 32)));
        check("out_valid", 64'(out_valid), 64'(exp_ov));
        check("mul_en", 64'(mul_en), 64'(started));
        if (out_valid && r && sb.size() > 0) begin
            check("out_p", 64'(out_p), sb[0].p);
            check("out_tag", 64'(out_tag), sb[0].tag);
            void'(sb.pop_front());
            n_pops++;
        end
        if (v && in_ready) begin
            sb.push_back('{p: 64'(a) * 64'(b), tag: 64'(t), rdy: cyc + 16});
            n_acc++;
        end
        @(posedge clk);
        cyc++;
        started = 1'b1;
        @(negedge clk);
    endtask

    task automatic drain(input int max_cycles);
        int k = 0;
        while (sb.size() > 0 && k < max_cycles) begin
            cycle(1'b0, '0, '0, '0, 1'b1);
            k++;
        end
        check("drain_empty", 64'(sb.size()), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_in_ready", 64'(in_ready), 0);
        check("rst_out_valid", 64'(out_valid), 0);
        check("rst_out_p", 64'(out_p), 0);
        check("rst_out_tag", 64'(out_tag), 0);
        check("rst_mul_a", 64'(mul_a), 0);
        check("rst_mul_b", 64'(mul_b), 0);
        check("rst_mul_en", 64'(mul_en), 0);
        sb.delete();
        started   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        int base;
        int k;
        int acc0;
        #3;
        do_reset();
        cycle(1'b0, '0, '0, '0, 1'b1);

        // Single maximal operation and its latency
        base = n_pops;
        cycle(1'b1, 13'd8191, 13'd8191, 4'd5, 1'b1);
        n = 0;
        while (!out_valid && n < 40) begin
            cycle(1'b0, '0, '0, '0, 1'b1);
            n++;
        end
        check("latency", 64'(n), 15);
        check("max_product", 64'(out_p), 64'd67092481);
        repeat (10) cycle(1'b0, '0, '0, '0, 1'b1);
        check("single_beats", 64'(n_pops - base), 1);

        // Back-to-back stream
        base = n_pops;
        for (int i = 0; i < 20; i++) cycle(1'b1, 13'(i), 13'(i + 100), 4'(i), 1'b1);
        drain(100);
        check("stream_beats", 64'(n_pops - base), 20);

        // Edge operands
        cycle(1'b1, 13'd0, 13'd8191, 4'd1, 1'b1);
        cycle(1'b1, 13'd8191, 13'd0, 4'd2, 1'b1);
        cycle(1'b1, 13'd1, 13'd1, 4'd3, 1'b1);
        cycle(1'b1, 13'd4096, 13'd2, 4'd4, 1'b1);
        drain(100);

        // Backpressure fills exactly the credit window
        acc0 = n_acc;
        base = n_pops;
        for (int i = 0; i < 60; i++)
            cycle(1'b1, 13'($urandom), 13'($urandom), 4'($urandom), 1'b0);
        check("bp_accepts", 64'(n_acc - acc0), 32);
        check("bp_in_ready_low", 64'(in_ready), 0);
        drain(200);
        check("bp_beats", 64'(n_pops - base), 32);

        // Random valid / ready
        acc0 = n_acc;
        k = 0;
        while ((n_acc - acc0) < 2000 && k < 20000) begin
            cycle(1'($urandom_range(0, 1)), 13'($urandom), 13'($urandom), 4'($urandom),
                  1'($urandom_range(0, 1)));
            k++;
        end
        check("rand_accepts", 64'(n_acc - acc0), 2000);
        drain(300);

        // Reset with ops in flight and results queued
        for (int i = 0; i < 15; i++) cycle(1'b1, 13'(i + 1), 13'(i + 2), 4'(i), 1'b0);
        repeat (5) cycle(1'b0, '0, '0, '0, 1'b0);
        do_reset();
        base = n_pops;
        repeat (40) cycle(1'b0, '0, '0, '0, 1'b1);
        check("no_stale_beats", 64'(n_pops - base), 0);
        cycle(1'b1, 13'd3, 13'd7, 4'd9, 1'b1);
        n = 0;
        while (!out_valid && n < 40) begin
            cycle(1'b0, '0, '0, '0, 1'b1);
            n++;
        end
        check("post_reset_latency", 64'(n), 15);
        check("post_reset_product", 64'(out_p), 21);
        drain(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
